// File: rtl/clct_peak_select_cclut.sv
// Picks the best of the per-CFEB ccLUT sorter outputs, qualifies it against thresholds, and
// emits one CLCT per rising quality peak followed by a programmable dead time.
//   state | meaning
//   IDLE  | waiting for a qualified Stage A pattern
//   RISE  | candidate held; may be replaced by better patterns up to MXRISE times
//   DEAD  | post-emission hold-off; Stage A ignored until dead_cnt reaches 0
module clct_peak_select_cclut #(
  parameter int MXCFEB = 7,
  parameter int MXPATB = 7,
  parameter int MXKEYB = 5,
  parameter int MXPATC = 11,
  parameter int MXRISE = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [MXCFEB*MXPATB-1:0]       pat_in,
  input  logic [MXCFEB*MXKEYB-1:0]       key_in,
  input  logic [MXCFEB*MXPATC-1:0]       carry_in,
  input  logic [2:0]                     hit_thresh,
  input  logic [3:0]                     pid_thresh,
  input  logic [3:0]                     dead_time,
  output logic                           clct_vpf,
  output logic [MXPATB-1:0]              clct_pat,
  output logic [$clog2(MXCFEB)+MXKEYB-1:0] clct_key,
  output logic [MXPATC-1:0]              clct_carry,
  output logic [15:0]                    clct_cnt,
  output logic                           busy
);

  localparam int CFEBW = $clog2(MXCFEB);
  localparam int KEYW  = CFEBW + MXKEYB;
  localparam int RISEW = $clog2(MXRISE + 1);
  localparam logic [RISEW-1:0] RISE_MAX = RISEW'(MXRISE);

  typedef enum logic [1:0] {IDLE, RISE, DEAD} state_t;

  logic [CFEBW-1:0]  best_idx;
  logic [MXPATB-1:0] best_pat;
  logic [MXKEYB-1:0] best_key;
  logic [MXPATC-1:0] best_carry;
  logic              qual_d;

  logic [MXPATB-1:0] a_pat_q;
  logic [KEYW-1:0]   a_key_q;
  logic [MXPATC-1:0] a_carry_q;
  logic              a_qual_q;

  state_t            state_q, state_d;
  logic [MXPATB-1:0] cand_pat_q, cand_pat_d;
  logic [KEYW-1:0]   cand_key_q, cand_key_d;
  logic [MXPATC-1:0] cand_carry_q, cand_carry_d;
  logic [RISEW-1:0]  rise_cnt_q, rise_cnt_d;
  logic [3:0]        dead_cnt_q, dead_cnt_d;
  logic              vpf_q, vpf_d;
  logic [MXPATB-1:0] clct_pat_q, clct_pat_d;
  logic [KEYW-1:0]   clct_key_q, clct_key_d;
  logic [MXPATC-1:0] clct_carry_q, clct_carry_d;
  logic [15:0]       clct_cnt_q, clct_cnt_d;
  logic              busy_q, busy_d;

  // Strict compare on pat[6:1] keeps the lowest CFEB index on a tie.
  always_comb begin
    best_idx   = '0;
    best_pat   = pat_in[MXPATB-1:0];
    best_key   = key_in[MXKEYB-1:0];
    best_carry = carry_in[MXPATC-1:0];
    for (int n = 1; n < MXCFEB; n++) begin
      if (pat_in[n*MXPATB+1 +: MXPATB-1] > best_pat[MXPATB-1:1]) begin
        best_idx   = CFEBW'(n);
        best_pat   = pat_in[n*MXPATB +: MXPATB];
        best_key   = key_in[n*MXKEYB +: MXKEYB];
        best_carry = carry_in[n*MXPATC +: MXPATC];
      end
    end
    qual_d = (best_pat[MXPATB-1:4] >= hit_thresh) && (best_pat[3:0] >= pid_thresh);
  end

  always_comb begin
    state_d      = state_q;
    cand_pat_d   = cand_pat_q;
    cand_key_d   = cand_key_q;
    cand_carry_d = cand_carry_q;
    rise_cnt_d   = rise_cnt_q;
    dead_cnt_d   = dead_cnt_q;
    vpf_d        = 1'b0;
    clct_pat_d   = clct_pat_q;
    clct_key_d   = clct_key_q;
    clct_carry_d = clct_carry_q;
    clct_cnt_d   = clct_cnt_q;
    case (state_q)
      IDLE: begin
        if (a_qual_q) begin
          cand_pat_d   = a_pat_q;
          cand_key_d   = a_key_q;
          cand_carry_d = a_carry_q;
          rise_cnt_d   = '0;
          state_d      = RISE;
        end
      end
      RISE: begin
        if (a_qual_q && (a_pat_q[MXPATB-1:1] > cand_pat_q[MXPATB-1:1]) &&
            (rise_cnt_q < RISE_MAX)) begin
          cand_pat_d   = a_pat_q;
          cand_key_d   = a_key_q;
          cand_carry_d = a_carry_q;
          rise_cnt_d   = rise_cnt_q + 1'b1;
        end else begin
          // The Stage A sample seen here is dropped, even if it qualifies.
          vpf_d        = 1'b1;
          clct_pat_d   = cand_pat_q;
          clct_key_d   = cand_key_q;
          clct_carry_d = cand_carry_q;
          clct_cnt_d   = (clct_cnt_q == 16'hFFFF) ? clct_cnt_q : clct_cnt_q + 16'd1;
          dead_cnt_d   = dead_time;
          state_d      = (dead_time != 4'd0) ? DEAD : IDLE;
        end
      end
      DEAD: begin
        if (dead_cnt_q <= 4'd1) begin
          dead_cnt_d = 4'd0;
          state_d    = IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_pat_q      <= '0;
      a_key_q      <= '0;
      a_carry_q    <= '0;
      a_qual_q     <= 1'b0;
      state_q      <= IDLE;
      cand_pat_q   <= '0;
      cand_key_q   <= '0;
      cand_carry_q <= '0;
      rise_cnt_q   <= '0;
      dead_cnt_q   <= '0;
      vpf_q        <= 1'b0;
      clct_pat_q   <= '0;
      clct_key_q   <= '0;
      clct_carry_q <= '0;
      clct_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      a_pat_q      <= best_pat;
      a_key_q      <= {best_idx, best_key};
      a_carry_q    <= best_carry;
      a_qual_q     <= qual_d;
      state_q      <= state_d;
      cand_pat_q   <= cand_pat_d;
      cand_key_q   <= cand_key_d;
      cand_carry_q <= cand_carry_d;
      rise_cnt_q   <= rise_cnt_d;
      dead_cnt_q   <= dead_cnt_d;
      vpf_q        <= vpf_d;
      clct_pat_q   <= clct_pat_d;
      clct_key_q   <= clct_key_d;
      clct_carry_q <= clct_carry_d;
      clct_cnt_q   <= clct_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign clct_vpf   = vpf_q;
  assign clct_pat   = clct_pat_q;
  assign clct_key   = clct_key_q;
  assign clct_carry = clct_carry_q;
  assign clct_cnt   = clct_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clct_peak_select_cclut.sv
// Bench for clct_peak_select_cclut: single-cycle vector table plus multi-cycle peak,
// dead-time, reset and counter-saturation sequences; emissions checked against a scoreboard.
module tb_clct_peak_select_cclut;

  logic        clock;
  logic        reset;
  logic [48:0] pat_in;
  logic [34:0] key_in;
  logic [76:0] carry_in;
  logic [2:0]  hit_thresh;
  logic [3:0]  pid_thresh;
  logic [3:0]  dead_time;
  logic        clct_vpf;
  logic [6:0]  clct_pat;
  logic [7:0]  clct_key;
  logic [10:0] clct_carry;
  logic [15:0] clct_cnt;
  logic        busy;

  clct_peak_select_cclut dut (
    .clock(clock), .reset(reset), .pat_in(pat_in), .key_in(key_in), .carry_in(carry_in),
    .hit_thresh(hit_thresh), .pid_thresh(pid_thresh), .dead_time(dead_time),
    .clct_vpf(clct_vpf), .clct_pat(clct_pat), .clct_key(clct_key), .clct_carry(clct_carry),
    .clct_cnt(clct_cnt), .busy(busy)
  );

  typedef struct {
    logic [48:0] pat;
    logic [34:0] key;
    logic [76:0] carry;
    logic [2:0]  hth;
    logic [3:0]  pth;
    bit          vpf;
    logic [6:0]  epat;
    logic [7:0]  ekey;
    logic [10:0] ecarry;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [6:0]  pat;
    logic [7:0]  key;
    logic [10:0] carry;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          vpf_seen = 0;
  logic [15:0] model_cnt = 16'd0;
  vec_t        vt[10];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every vpf pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (clct_vpf === 1'b1) begin
      exp_t e;
      vpf_seen++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_vpf: got vpf at cycle %0d pat 0x%0h key %0d, expected none",
                 cyc, clct_pat, clct_key);
      end else begin
        e = sb.pop_front();
        chk("vpf_cycle", cyc, e.cyc);
        chk("clct_pat", {25'd0, clct_pat}, {25'd0, e.pat});
        chk("clct_key", {24'd0, clct_key}, {24'd0, e.key});
        chk("clct_carry", {21'd0, clct_carry}, {21'd0, e.carry});
        chk("clct_cnt", {16'd0, clct_cnt}, {16'd0, e.cnt});
      end
    end
  end

  task automatic expect_emit(input int at, input logic [6:0] p, input logic [7:0] k,
                             input logic [10:0] cr);
    model_cnt = (model_cnt == 16'hFFFF) ? 16'hFFFF : model_cnt + 16'd1;
    sb.push_back('{cyc: at, pat: p, key: k, carry: cr, cnt: model_cnt});
  endtask

  task automatic clear_in();
    pat_in = '0;
    key_in = '0;
    carry_in = '0;
  endtask

  task automatic drive_cfeb(input int c, input logic [4:0] k, input logic [6:0] p,
                            input logic [10:0] cr);
    clear_in();
    pat_in[c*7 +: 7]    = p;
    key_in[c*5 +: 5]    = k;
    carry_in[c*11 +: 11] = cr;
  endtask

  task automatic end_seq(input string nm, input int seen0, input int exp_n);
    chk({nm, "_vpf_count"}, vpf_seen - seen0, exp_n);
    chk({nm, "_sb_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  function automatic vec_t mk(input logic [2:0] h, input logic [3:0] pt, input bit e,
                              input logic [6:0] ep, input logic [7:0] ek, input logic [10:0] ec);
    vec_t v;
    v.pat = '0; v.key = '0; v.carry = '0;
    v.hth = h; v.pth = pt; v.vpf = e; v.epat = ep; v.ekey = ek; v.ecarry = ec;
    return v;
  endfunction

  function automatic vec_t put(input vec_t v, input int c, input logic [4:0] k,
                               input logic [6:0] p, input logic [10:0] cr);
    v.pat[c*7 +: 7]     = p;
    v.key[c*5 +: 5]     = k;
    v.carry[c*11 +: 11] = cr;
    return v;
  endfunction

  initial begin
    int n, seen0, busy_low;

    vt[0] = put(mk(3'd3, 4'd2, 1, 7'h5A, 8'd106, 11'h5A5), 3, 5'd10, 7'h5A, 11'h5A5);
    vt[1] = put(put(put(mk(3'd3, 4'd2, 1, 7'h5A, 8'd36, 11'h111),
                    1, 5'd4, 7'h5A, 11'h111), 5, 5'd4, 7'h5A, 11'h555), 2, 5'd9, 7'h5B, 11'h222);
    vt[2] = put(mk(3'd3, 4'd2, 0, 7'h0, 8'd0, 11'h0), 0, 5'd7, 7'h29, 11'h123);
    vt[3] = put(mk(3'd3, 4'd2, 0, 7'h0, 8'd0, 11'h0), 6, 5'd31, 7'h31, 11'h456);
    vt[4] = put(mk(3'd3, 4'd1, 1, 7'h31, 8'd223, 11'h456), 6, 5'd31, 7'h31, 11'h456);
    vt[5] = put(mk(3'd7, 4'd15, 1, 7'h7F, 8'd0, 11'h7FF), 0, 5'd0, 7'h7F, 11'h7FF);
    vt[6] = put(put(mk(3'd3, 4'd2, 1, 7'h62, 8'd131, 11'h0AB),
                    2, 5'd5, 7'h42, 11'h3CC), 4, 5'd3, 7'h62, 11'h0AB);
    vt[7] = put(put(mk(3'd3, 4'd2, 0, 7'h0, 8'd0, 11'h0),
                    0, 5'd1, 7'h70, 11'h001), 1, 5'd2, 7'h3F, 11'h002);
    vt[8] = put(mk(3'd3, 4'd2, 1, 7'h32, 8'd160, 11'h321), 5, 5'd0, 7'h32, 11'h321);
    vt[9] = put(put(mk(3'd3, 4'd2, 1, 7'h7F, 8'd177, 11'h0F0),
                    5, 5'd17, 7'h7F, 11'h0F0), 6, 5'd1, 7'h7E, 11'h00F);

    reset = 1'b1;
    clear_in();
    hit_thresh = 3'd3;
    pid_thresh = 4'd2;
    dead_time  = 4'd0;
    repeat (2) @(negedge clock);
    chk("rst_vpf", {31'd0, clct_vpf}, 0);
    chk("rst_pat", {25'd0, clct_pat}, 0);
    chk("rst_key", {24'd0, clct_key}, 0);
    chk("rst_carry", {21'd0, clct_carry}, 0);
    chk("rst_cnt", {16'd0, clct_cnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      seen0 = vpf_seen;
      hit_thresh = vt[i].hth;
      pid_thresh = vt[i].pth;
      pat_in   = vt[i].pat;
      key_in   = vt[i].key;
      carry_in = vt[i].carry;
      n = cyc;
      if (vt[i].vpf) expect_emit(n + 3, vt[i].epat, vt[i].ekey, vt[i].ecarry);
      @(negedge clock);
      clear_in();
      repeat (6) @(negedge clock);
      end_seq($sformatf("vec%0d", i), seen0, vt[i].vpf ? 1 : 0);
    end

    hit_thresh = 3'd3;
    pid_thresh = 4'd2;

    // Rising peak: two replacements then a worse sample ends it.
    seen0 = vpf_seen;
    n = cyc;
    expect_emit(n + 5, 7'h62, 8'd1, 11'h062);
    drive_cfeb(0, 5'd1, 7'h42, 11'h042); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h52, 11'h052); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h62, 11'h062); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h52, 11'h152); @(negedge clock);
    clear_in();
    repeat (7) @(negedge clock);
    end_seq("rise_a", seen0, 1);

    // Third replacement blocked by the rise limit; the better sample is discarded.
    seen0 = vpf_seen;
    n = cyc;
    expect_emit(n + 5, 7'h62, 8'd1, 11'h062);
    drive_cfeb(0, 5'd1, 7'h42, 11'h042); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h52, 11'h052); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h62, 11'h062); @(negedge clock);
    drive_cfeb(0, 5'd1, 7'h66, 11'h066); @(negedge clock);
    clear_in();
    repeat (7) @(negedge clock);
    end_seq("rise_b", seen0, 1);

    // Zero dead time with a continuous qualified input: a pulse every 2 cycles.
    seen0 = vpf_seen;
    n = cyc;
    expect_emit(n + 3, 7'h5A, 8'd106, 11'h5A5);
    expect_emit(n + 5, 7'h5A, 8'd106, 11'h5A5);
    expect_emit(n + 7, 7'h5A, 8'd106, 11'h5A5);
    drive_cfeb(3, 5'd10, 7'h5A, 11'h5A5);
    repeat (6) @(negedge clock);
    clear_in();
    repeat (6) @(negedge clock);
    end_seq("dead0", seen0, 3);

    // Dead time 4, continuous input; change to 1 mid-DEAD must not move the next pulse.
    seen0 = vpf_seen;
    busy_low = 0;
    dead_time = 4'd4;
    n = cyc;
    expect_emit(n + 3, 7'h5A, 8'd106, 11'h5A5);
    expect_emit(n + 9, 7'h5A, 8'd106, 11'h5A5);
    expect_emit(n + 15, 7'h5A, 8'd106, 11'h5A5);
    drive_cfeb(3, 5'd10, 7'h5A, 11'h5A5);
    for (int k = 0; k < 20; k++) begin
      if (k >= 4 && k <= 9 && busy === 1'b0) busy_low++;
      if (k == 3) chk("dead_busy_after_emit", {31'd0, busy}, 1);
      if (k == 11) dead_time = 4'd1;
      if (k == 15) clear_in();
      @(negedge clock);
    end
    chk("dead_busy_low_cycles", busy_low, 1);
    chk("dead_busy_idle_end", {31'd0, busy}, 0);
    end_seq("dead4", seen0, 3);
    dead_time = 4'd0;

    // Reset mid-RISE discards the candidate and clears everything.
    seen0 = vpf_seen;
    drive_cfeb(0, 5'd2, 7'h42, 11'h042); @(negedge clock);
    drive_cfeb(0, 5'd2, 7'h52, 11'h052); @(negedge clock);
    chk("rise_busy_before_reset", {31'd0, busy}, 1);
    clear_in();
    reset = 1'b1;
    #1;
    model_cnt = 16'd0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_pat", {25'd0, clct_pat}, 0);
    chk("mid_rst_key", {24'd0, clct_key}, 0);
    chk("mid_rst_carry", {21'd0, clct_carry}, 0);
    chk("mid_rst_cnt", {16'd0, clct_cnt}, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    end_seq("mid_rst", seen0, 0);

    // Counter saturation at 0xFFFF.
    force dut.clct_cnt_q = 16'hFFFE;
    #1;
    release dut.clct_cnt_q;
    model_cnt = 16'hFFFE;
    @(negedge clock);
    for (int r = 0; r < 2; r++) begin
      seen0 = vpf_seen;
      n = cyc;
      expect_emit(n + 3, 7'h5A, 8'd106, 11'h5A5);
      drive_cfeb(3, 5'd10, 7'h5A, 11'h5A5);
      @(negedge clock);
      clear_in();
      repeat (6) @(negedge clock);
      end_seq($sformatf("sat%0d", r), seen0, 1);
    end
    chk("sat_final_cnt", {16'd0, clct_cnt}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clct_peak_select_cclut.md
# clct_peak_select_ccLUT

Downstream stage of the per-CFEB best-1-of-32 ccLUT pattern sorters. Each cycle it takes the best pattern, 5-bit key and 11-bit ccLUT carry from all 7 CFEB sorters. It registers the best of the 7 and qualifies it against hit and pattern-ID thresholds. A peak-finding FSM then emits one CLCT candidate per rising pattern-quality peak and applies a programmable dead time after each emission.

## Interface
Parameters:
- MXCFEB, 7: number of CFEB sorter inputs.
- MXPATB, 7: pattern bits; [6:4] are hits, [3:0] are pattern ID, and [0] is bend direction.
- MXKEYB, 5: key bits per CFEB.
- MXPATC, 11: ccLUT carry bits.
- MXRISE, 2: maximum number of candidate replacements per peak.

Ports:
- clock, in, 1: sole clock. All state updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- pat_in, in, MXCFEB*MXPATB: CFEB n pattern at bits [n*7+6:n*7].
- key_in, in, MXCFEB*MXKEYB: CFEB n key at bits [n*5+4:n*5].
- carry_in, in, MXCFEB*MXPATC: CFEB n carry at bits [n*11+10:n*11].
- hit_thresh, in, 3: minimum value of pat[6:4].
- pid_thresh, in, 4: minimum value of pat[3:0].
- dead_time, in, 4: number of cycles inputs are ignored after an emission.
- clct_vpf, out, 1: one-cycle pulse marking a valid emitted CLCT.
- clct_pat, out, 7: pattern of the emitted CLCT.
- clct_key, out, 8: key of the emitted CLCT, equal to cfeb*32 + key (range 0–223).
- clct_carry, out, 11: carry of the emitted CLCT.
- clct_cnt, out, 16: saturating count of emissions.
- busy, out, 1: high in the RISE and DEAD states.

## Operation
- **Stage A (registered).**
  - Selects the best of 7 CFEBs by comparing pat[6:1] only.
  - On a tie, the lower CFEB index wins.
  - Registers a_pat, a_key (8 bits, {cfeb[2:0], key[4:0]}), a_carry.
  - Computes a_qual = (a_pat[6:4] >= hit_thresh) && (a_pat[3:0] >= pid_thresh).
- **FSM**, evaluated on Stage A contents. States: IDLE, RISE, DEAD. A candidate register holds cand_pat, cand_key and cand_carry.
  - **IDLE:** if a_qual, capture Stage A into the candidate, clear rise_cnt, go to RISE. Otherwise stay in IDLE.
  - **RISE, replace:** if a_qual and a_pat[6:1] > cand_pat[6:1] and rise_cnt < MXRISE, replace the candidate, increment rise_cnt, stay in RISE. Equal quality does not replace.
  - **RISE, emit:** otherwise, emit:
    - Register the candidate into clct_pat, clct_key and clct_carry.
    - Set clct_vpf = 1 for that one cycle.
    - Increment clct_cnt, saturating at 0xFFFF.
    - Load dead_cnt = dead_time.
    - Go to DEAD if dead_time != 0, else to IDLE.
    - The Stage A sample that ended the peak is discarded and is never captured.
  - **DEAD:** ignore Stage A. Decrement dead_cnt; go to IDLE in the cycle it reaches 0. dead_time is sampled only at emission, so changes during DEAD have no effect.
- **Outputs between emissions:** clct_pat, clct_key and clct_carry hold the last emitted values.
- **Thresholds:** hit_thresh and pid_thresh are used combinationally each cycle. A change takes effect on the next Stage A evaluation.

## Timing
- Reset values (asynchronous, immediate): all Stage A registers 0, a_qual 0, FSM in IDLE, candidate 0, rise_cnt 0, dead_cnt 0, clct_vpf 0, clct_pat 0, clct_key 0, clct_carry 0, clct_cnt 0, busy 0.
- Reset asserted mid-RISE or mid-DEAD discards the candidate; no emission occurs.
- Latency, with inputs sampled at edge E0:
  - Stage A is valid after E0.
  - The candidate is captured at E1.
  - The earliest clct_vpf is high after E2, when the E1 sample is not better.
  - Each replacement adds one cycle. Worst case: vpf after edge E(2+MXRISE).
- Rising-edge gap: with dead_time = D, the minimum gap between vpf pulses is D+2 cycles.
  - With D = 0 the FSM goes RISE→IDLE, and IDLE can capture on the next cycle, giving a gap of 2.
- Qualification is not re-checked at emission; a captured candidate always emits.
- busy is registered and equals (state != IDLE).

## Test plan
- **Single peak.** CFEB 3 key 10, pat 0x5A (hits 5, pid 10) for one cycle; all other inputs 0; hit_thresh 3, pid_thresh 2, dead_time 0.
  - Expect clct_vpf high exactly one cycle, after edge E2.
  - Expect clct_key 106, clct_pat 0x5A, carry passed through, clct_cnt 1.
- **Rising sequence.** pat 0x42 → 0x52 → 0x62 → 0x52 on consecutive cycles, MXRISE = 2.
  - Expect one vpf, after E4, with clct_pat 0x62.
  - Repeat with 0x42 → 0x52 → 0x62 → 0x66: the third replacement is blocked, so 0x62 emits after E4 and 0x66 is discarded (no second vpf).
- **Tie across CFEBs.** CFEB 1 key 4 and CFEB 5 key 4, both pat 0x5A, plus CFEB 2 pat 0x5B (differs only in lsb).
  - Expect clct_key 36, since CFEB 1 wins the tie on [6:1].
- **Thresholds.** pat 0x29 (hits 2) with hit_thresh 3 → no vpf. Then pat 0x31 (pid 1) with pid_thresh 2 → no vpf.
  - Set pid_thresh 1 → vpf with clct_pat 0x31.
- **Dead time.** dead_time 4; qualified input 0x5A on every cycle.
  - Expect vpf every 6 cycles and busy low for exactly one cycle between peaks.
  - Change dead_time to 1 during DEAD → current gap is unchanged.
- **Reset and counter.** Assert reset for one cycle mid-RISE → no vpf, all outputs 0.
  - Force clct_cnt to 0xFFFF, emit again → count stays 0xFFFF.
